// File: rtl/xbee_msg_sequencer.sv
// Queues colour-detection events and streams each one to the XBee UART transmitter
// as the 10-byte ASCII message "SI-W<node>-<c1><c2>-#", one byte per valid/done handshake.
module xbee_msg_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ACCEPT_TIMEOUT = 1024
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       COLOR_VALID,
    input  logic [2:0] COLOR,
    input  logic [3:0] NODE,
    input  logic       TX_DONE,
    output logic       TX_DATA_VALID,
    output logic [7:0] TX_BYTE,
    output logic       BUSY,
    output logic       DROPPED,
    output logic [7:0] MSG_COUNT,
    output logic [2:0] DBG_STATE
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;

    // Handshake: TX_DATA_VALID is high for exactly one cycle per byte issue, with
    // TX_BYTE already stable; the transmitter accepts by pulling TX_DONE low and
    // finishes by raising it again. No fall within ACCEPT_TIMEOUT cycles re-issues.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD        = 3'd1,
        ISSUE       = 3'd2,
        WAIT_ACCEPT = 3'd3,
        WAIT_DONE   = 3'd4,
        ADVANCE     = 3'd5
    } state_t;

    state_t          state, state_next;
    logic [5:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic [3:0]      idx;
    logic [TW-1:0]   tmo_cnt;
    logic [1:0]      msg_color;
    logic [3:0]      msg_node;
    logic [7:0]      cur_byte, node_digit, code_1, code_2;
    logic            push_req, push, pop, full;

    assign push_req = COLOR_VALID && !COLOR[2] && (COLOR[1:0] != 2'd0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = (state == IDLE) && (count != '0) && TX_DONE;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    assign TX_DATA_VALID = (state == ISSUE);
    assign DBG_STATE     = state;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (pop) state_next = LOAD;
            LOAD:        state_next = ISSUE;
            ISSUE:       state_next = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (!TX_DONE)
                    state_next = WAIT_DONE;
                else if (tmo_cnt == TW'(ACCEPT_TIMEOUT - 1))
                    state_next = ISSUE;
            end
            WAIT_DONE:   if (TX_DONE) state_next = ADVANCE;
            ADVANCE:     state_next = (idx == 4'd9) ? IDLE : LOAD;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        node_digit = (msg_node <= 4'd9) ? (8'h30 + {4'h0, msg_node}) : 8'h3F;
        code_1     = (msg_color == 2'd1) ? 8'h46 : 8'h43;
        case (msg_color)
            2'd1:    code_2 = 8'h49;
            2'd2:    code_2 = 8'h54;
            default: code_2 = 8'h53;
        endcase
        case (idx)
            4'd0:    cur_byte = 8'h53;
            4'd1:    cur_byte = 8'h49;
            4'd2:    cur_byte = 8'h2D;
            4'd3:    cur_byte = 8'h57;
            4'd4:    cur_byte = node_digit;
            4'd5:    cur_byte = 8'h2D;
            4'd6:    cur_byte = code_1;
            4'd7:    cur_byte = code_2;
            4'd8:    cur_byte = 8'h2D;
            4'd9:    cur_byte = 8'h23;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (push)
            mem[wr_ptr] <= {COLOR[1:0], NODE};
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            idx       <= '0;
            tmo_cnt   <= '0;
            msg_color <= '0;
            msg_node  <= '0;
            TX_BYTE   <= '0;
            MSG_COUNT <= '0;
            BUSY      <= 1'b0;
            DROPPED   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr                <= rd_ptr + AW'(1);
                {msg_color, msg_node} <= mem[rd_ptr];
                idx                   <= '0;
            end
            if (state == LOAD)
                TX_BYTE <= cur_byte;
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT_ACCEPT)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (state == ADVANCE) begin
                if (idx == 4'd9)
                    MSG_COUNT <= MSG_COUNT + 8'd1;
                else
                    idx <= idx + 4'd1;
            end
            DROPPED <= push_req && full && !pop;
            BUSY    <= (state_next != IDLE) || (count_next != '0);
        end
    end

endmodule

// File: tb/tb_xbee_msg_sequencer.sv
// Directed bench for xbee_msg_sequencer: a transmitter model answers each byte strobe,
// a monitor checks every strobed byte against the expected-byte queue.
module tb_xbee_msg_sequencer;

    localparam int TMO = 16;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       COLOR_VALID;
    logic [2:0] COLOR;
    logic [3:0] NODE;
    logic       TX_DONE;
    logic       TX_DATA_VALID;
    logic [7:0] TX_BYTE;
    logic       BUSY;
    logic       DROPPED;
    logic [7:0] MSG_COUNT;
    logic [2:0] DBG_STATE;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int drop_cnt = 0;
    int strobe_cnt = 0;
    bit tx_en  = 1'b1;
    bit mon_en = 1'b1;

    xbee_msg_sequencer #(.FIFO_DEPTH(4), .ACCEPT_TIMEOUT(TMO)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .COLOR_VALID(COLOR_VALID), .COLOR(COLOR),
        .NODE(NODE), .TX_DONE(TX_DONE), .TX_DATA_VALID(TX_DATA_VALID), .TX_BYTE(TX_BYTE),
        .BUSY(BUSY), .DROPPED(DROPPED), .MSG_COUNT(MSG_COUNT), .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    always #5 CLOCK = ~CLOCK;
    always @(posedge CLOCK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending bytes, required 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    // transmitter model: accepts a strobe, stays busy for three cycles
    initial begin
        TX_DONE = 1'b1;
        forever begin
            @(posedge CLOCK);
            #1;
            if (tx_en && TX_DATA_VALID && !RESET) begin
                TX_DONE = 1'b0;
                repeat (3) @(posedge CLOCK);
                #1;
                TX_DONE = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge CLOCK) begin
        if (DROPPED) drop_cnt++;
        if (!RESET && TX_DATA_VALID) begin
            strobe_cnt++;
            if (mon_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: got byte %0h, required no strobe", TX_BYTE);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (TX_BYTE !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %0h, required %0h", TX_BYTE, e);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic push_vec(input logic [79:0] v);
        for (int i = 0; i < 10; i++) exp_q.push_back(v[79-8*i -: 8]);
    endtask

    task automatic sync;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic ev(input logic [2:0] c, input logic [3:0] n);
        COLOR_VALID = 1'b1;
        COLOR = c;
        NODE = n;
        @(posedge CLOCK);
        #1;
        COLOR_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge CLOCK);
            #1;
            if (exp_q.size() == 0 && !BUSY) break;
        end
        n_checks++;
        if (k >= 3000) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending bytes busy=%0b, required 0 and 0", name, exp_q.size(), BUSY);
        end
    endtask

    task automatic wait_strobe(input string name, output int at);
        int k;
        at = -1;
        for (k = 0; k < 4 * TMO; k++) begin
            @(negedge CLOCK);
            if (TX_DATA_VALID) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s: got no strobe, required a strobe within %0d cycles", name, 4 * TMO);
        end
    endtask

    initial begin
        int d0, t0, t1, t2, s0;
        RESET = 1'b1;
        COLOR_VALID = 1'b0;
        COLOR = '0;
        NODE = '0;
        #1;
        chk("reset_valid", TX_DATA_VALID, 0);
        chk("reset_byte", TX_BYTE, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_dropped", DROPPED, 0);
        chk("reset_count", MSG_COUNT, 0);
        chk("reset_state", DBG_STATE, 0);
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;

        // single red event from node 3
        push_vec(80'h53_49_2D_57_33_2D_46_49_2D_23);
        sync;
        ev(3'd1, 4'd3);
        chk("busy_after_strobe", BUSY, 1);
        wait_idle("msg1");
        chk("msg_count_1", MSG_COUNT, 1);
        chk("busy_falls", BUSY, 0);
        chk("idle_after_msg", DBG_STATE, 0);

        // invalid colours are ignored
        d0 = drop_cnt;
        sync;
        ev(3'd0, 4'd3);
        ev(3'd5, 4'd3);
        repeat (4) @(negedge CLOCK);
        chk("invalid_busy", BUSY, 0);
        chk("invalid_drop", drop_cnt - d0, 0);
        chk("invalid_count", MSG_COUNT, 1);

        // six back-to-back events: one in flight, four queued, last one dropped
        push_vec(80'h53_49_2D_57_30_2D_46_49_2D_23);
        push_vec(80'h53_49_2D_57_31_2D_43_54_2D_23);
        push_vec(80'h53_49_2D_57_32_2D_43_53_2D_23);
        push_vec(80'h53_49_2D_57_39_2D_46_49_2D_23);
        push_vec(80'h53_49_2D_57_35_2D_43_54_2D_23);
        d0 = drop_cnt;
        sync;
        ev(3'd1, 4'd0);
        ev(3'd2, 4'd1);
        ev(3'd3, 4'd2);
        ev(3'd1, 4'd9);
        ev(3'd2, 4'd5);
        ev(3'd3, 4'd7);
        wait_idle("burst");
        chk("burst_drop", drop_cnt - d0, 1);
        chk("msg_count_6", MSG_COUNT, 6);

        // out-of-range node shows '?'
        push_vec(80'h53_49_2D_57_3F_2D_43_54_2D_23);
        sync;
        ev(3'd2, 4'd12);
        wait_idle("node12");
        chk("msg_count_7", MSG_COUNT, 7);

        // no accept: the first byte is re-issued every TMO+1 cycles
        tx_en = 1'b0;
        mon_en = 1'b0;
        sync;
        ev(3'd3, 4'd1);
        wait_strobe("retry_first", t0);
        chk("retry_byte0", TX_BYTE, 8'h53);
        wait_strobe("retry_second", t1);
        chk("retry_byte1", TX_BYTE, 8'h53);
        chk("retry_gap1", t1 - t0, TMO + 1);
        wait_strobe("retry_third", t2);
        chk("retry_byte2", TX_BYTE, 8'h53);
        chk("retry_gap2", t2 - t1, TMO + 1);
        #1;
        push_vec(80'h53_49_2D_57_31_2D_43_53_2D_23);
        mon_en = 1'b1;
        tx_en = 1'b1;
        wait_idle("retry_msg");
        chk("msg_count_8", MSG_COUNT, 8);

        // reset while byte 5 is being strobed
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'h57);
        exp_q.push_back(8'h3F);
        sync;
        ev(3'd1, 4'd15);
        for (int k = 0; k < 500; k++) begin
            @(negedge CLOCK);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk("byte5_reached", exp_q.size(), 0);
        chk("pre_reset_valid", TX_DATA_VALID, 1);
        RESET = 1'b1;
        #1;
        chk("async_valid", TX_DATA_VALID, 0);
        chk("async_count", MSG_COUNT, 0);
        chk("async_busy", BUSY, 0);
        chk("async_byte", TX_BYTE, 0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        s0 = strobe_cnt;
        repeat (40) @(negedge CLOCK);
        chk("no_resume", strobe_cnt - s0, 0);
        chk("post_reset_busy", BUSY, 0);
        chk("post_reset_count", MSG_COUNT, 0);

        // a fresh event after reset goes through normally
        push_vec(80'h53_49_2D_57_34_2D_43_53_2D_23);
        sync;
        ev(3'd3, 4'd4);
        wait_idle("after_reset");
        chk("msg_count_after_reset", MSG_COUNT, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
